// File: rtl/qm_pkg.sv
// Shared types and helpers for the truth-table readback harness.
// Holds the sweep FSM encoding, the default table depth and a width helper.
package qm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam int TT_N_IN  = 5;
    localparam int TT_DEPTH = 2**TT_N_IN;

    // Bits needed to hold value-1; never less than one so a 1-cycle settle still gets a flop.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Load / count-down counter with a zero flag, used to hold each vector stable
// long enough for the netlist under test to settle.
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all input vectors of a combinational netlist, captures its output into a
// truth table and compares it against a latched expected minterm mask.
module truth_table_extractor
    import qm_pkg::*;
#(
    parameter  int N_IN          = TT_N_IN,
    parameter  int SETTLE_CYCLES = 4,
    localparam int DEPTH         = 2**N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DEPTH-1:0]  expected_i,
    input  logic              dut_i,
    output logic [N_IN-1:0]   vec_o,
    output logic              busy,
    output logic              done,
    output logic [DEPTH-1:0]  table_o,
    output logic              mismatch,
    output logic [N_IN-1:0]   first_fail,
    output logic [N_IN:0]     fail_count
);

    localparam int CNT_W = clog2(SETTLE_CYCLES);
    localparam int FC_W  = N_IN + 1;

    tt_state_e state_q, state_d;

    logic [N_IN-1:0]  vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DEPTH-1:0] table_q, table_d;
    logic [DEPTH-1:0] exp_q, exp_d;
    logic             mismatch_q, mismatch_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic [FC_W-1:0]  fail_count_q, fail_count_d;

    logic accept_s;
    logic last_s;
    logic load_s;
    logic dec_s;
    logic zero_s;

    assign accept_s = (state_q == IDLE) && start;
    assign last_s   = (vec_q == N_IN'(DEPTH - 1));
    assign load_s   = accept_s || ((state_q == SAMPLE) && !last_s);
    assign dec_s    = (state_q == SETTLE);

    settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SETTLE;
                else       state_d = IDLE;
            end
            SETTLE: begin
                if (zero_s) state_d = SAMPLE;
                else        state_d = SETTLE;
            end
            SAMPLE: begin
                if (last_s) state_d = DONE;
                else        state_d = SETTLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture/compare datapath and status outputs, all computed from the current state.
    always_comb begin
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        table_d      = table_q;
        exp_d        = exp_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        fail_count_d = fail_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d        = {N_IN{1'b0}};
                    busy_d       = 1'b1;
                    table_d      = {DEPTH{1'b0}};
                    exp_d        = expected_i;
                    mismatch_d   = 1'b0;
                    first_fail_d = {N_IN{1'b0}};
                    fail_count_d = {FC_W{1'b0}};
                end else begin
                    busy_d = busy_q;
                end
            end
            SAMPLE: begin
                table_d[vec_q] = dut_i;
                if (dut_i != exp_q[vec_q]) begin
                    fail_count_d = fail_count_q + FC_W'(1);
                    if (!mismatch_q) begin
                        first_fail_d = vec_q;
                        mismatch_d   = 1'b1;
                    end else begin
                        first_fail_d = first_fail_q;
                    end
                end else begin
                    fail_count_d = fail_count_q;
                end
                if (!last_s) vec_d = vec_q + N_IN'(1);
                else         vec_d = vec_q;
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q        <= {N_IN{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            table_q      <= {DEPTH{1'b0}};
            exp_q        <= {DEPTH{1'b0}};
            mismatch_q   <= 1'b0;
            first_fail_q <= {N_IN{1'b0}};
            fail_count_q <= {FC_W{1'b0}};
        end else begin
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            table_q      <= table_d;
            exp_q        <= exp_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign vec_o      = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_o    = table_q;
    assign mismatch   = mismatch_q;
    assign first_fail = first_fail_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: a 4-cycle and a 1-cycle settle build swept side by side
// against a glitchy table-driven netlist, checked against a whole-table reference model.
module tb_truth_table_extractor;

    localparam int N = 5;
    localparam int D = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n  = 1'b0;
    logic          start4 = 1'b0;
    logic          start1 = 1'b0;
    logic [D-1:0]  expected = '0;
    logic [D-1:0]  dut_tbl = '0;
    logic          dut4 = 1'b0;
    logic          dut1 = 1'b0;

    logic [N-1:0]  vec4, vec1, ff4, ff1;
    logic          busy4, busy1, done4, done1, mm4, mm1;
    logic [D-1:0]  tab4, tab1;
    logic [N:0]    fc4, fc1;

    int total = 0;
    int bad   = 0;

    truth_table_extractor #(.N_IN(N), .SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected_i(expected), .dut_i(dut4),
        .vec_o(vec4), .busy(busy4), .done(done4), .table_o(tab4), .mismatch(mm4),
        .first_fail(ff4), .fail_count(fc4)
    );

    truth_table_extractor #(.N_IN(N), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected_i(expected), .dut_i(dut1),
        .vec_o(vec1), .busy(busy1), .done(done1), .table_o(tab1), .mismatch(mm1),
        .first_fail(ff1), .fail_count(fc1)
    );

    // Netlist stand-in: random output for the cycle right after the vector moves, then table value.
    logic [N-1:0] prev4 = '0;
    logic [N-1:0] prev1 = '0;
    always begin
        @(posedge clk);
        #1;
        dut4  = (vec4 != prev4) ? 1'($urandom) : dut_tbl[vec4];
        dut1  = (vec1 != prev1) ? 1'($urandom) : dut_tbl[vec1];
        prev4 = vec4;
        prev1 = vec1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int lowest_set(input logic [D-1:0] v);
        for (int i = 0; i < D; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Sweep both builds with the same table; optionally poke start and expected mid-sweep.
    task automatic sweep(input logic [D-1:0] tbl, input logic [D-1:0] exp_tbl,
                         input bit disturb, input string tag);
        int lat4;
        int lat1;
        logic [D-1:0] diff;
        dut_tbl  = tbl;
        expected = exp_tbl;
        @(negedge clk);
        start4 = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start1 = 1'b0;
        check_eq({tag, ".busy_on"}, 64'(busy4), 64'd1);
        lat4 = 0;
        lat1 = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done4 && lat4 == 0) lat4 = c;
            if (done1 && lat1 == 0) lat1 = c;
            if (disturb && (c == 20 || c == 40)) begin
                start4   = 1'b1;
                start1   = 1'b1;
                expected = $urandom;
            end else if (c == 160) begin
                start4 = 1'b1;
                start1 = 1'b0;
            end else begin
                start4 = 1'b0;
                start1 = 1'b0;
            end
        end
        diff = tbl ^ exp_tbl;
        check_eq({tag, ".lat4"},  64'(lat4), 64'(D * 5 + 1));
        check_eq({tag, ".lat1"},  64'(lat1), 64'(D * 2 + 1));
        check_eq({tag, ".idle4"}, 64'(busy4), 64'd0);
        check_eq({tag, ".idle1"}, 64'(busy1), 64'd0);
        check_eq({tag, ".table4"}, 64'(tab4), 64'(tbl));
        check_eq({tag, ".table1"}, 64'(tab1), 64'(tbl));
        check_eq({tag, ".mm4"}, 64'(mm4), 64'(diff != '0));
        check_eq({tag, ".mm1"}, 64'(mm1), 64'(diff != '0));
        check_eq({tag, ".fc4"}, 64'(fc4), 64'($countones(diff)));
        check_eq({tag, ".fc1"}, 64'(fc1), 64'($countones(diff)));
        check_eq({tag, ".ff4"}, 64'(ff4), 64'(lowest_set(diff)));
        check_eq({tag, ".ff1"}, 64'(ff1), 64'(lowest_set(diff)));
    endtask

    logic [D-1:0] netlist_tbl;
    logic [D-1:0] rt;
    logic [D-1:0] re;
    bit           hit;

    initial begin
        // Source table of a 5-input netlist, vector = {a,b,c,d,s}.
        for (int v = 0; v < D; v++) begin
            logic [N-1:0] x;
            x = N'(v);
            netlist_tbl[v] = x[0] ? ((x[4] & x[3]) | x[2]) : ((~x[4] & x[1]) | (x[3] & ~x[2]));
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset4", 64'({vec4, busy4, done4, tab4, mm4, ff4, fc4}), 64'd0);
        check_eq("reset1", 64'({vec1, busy1, done1, tab1, mm1, ff1, fc1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, "alt_ok");
        sweep(32'hAAAA_AAAA, 32'hAAAA_AAAB, 1'b0, "alt_bit0");
        sweep(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "ones");
        sweep(netlist_tbl, netlist_tbl, 1'b0, "netlist_ok");
        sweep(netlist_tbl, netlist_tbl ^ (32'd1 << 17), 1'b1, "netlist_b17");

        for (int i = 0; i < 6; i++) begin
            rt = $urandom;
            case (i % 3)
                0:       re = rt;
                1:       re = rt ^ (32'd1 << $urandom_range(0, D - 1));
                default: re = $urandom;
            endcase
            sweep(rt, re, 1'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a sweep, once vector 10 is on the bus.
        dut_tbl  = 32'hFFFF_FFFF;
        expected = 32'h0;
        @(negedge clk);
        start4 = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start1 = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 120 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (vec4 == N'(10)) hit = 1'b1;
        end
        check_eq("rst.reach_vec10", 64'(hit), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst.async4", 64'({vec4, busy4, done4, tab4, mm4, ff4, fc4}), 64'd0);
        check_eq("rst.async1", 64'({vec1, busy1, done1, tab1, mm1, ff1, fc1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst.stay_idle", 64'({busy4, busy1, vec4, vec1}), 64'd0);

        sweep(netlist_tbl, ~netlist_tbl, 1'b1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
